// File: rtl/draw_ctrl.sv
// Frame draw sequencer (BG -> per-tick pacman/win/over/exit); DRAW_WATCHDOG_EN adds a per-draw abort timer.
// One-cycle latency: all outputs registered, starts pulse on DRAW entry; no backpressure beyond drawer done pulses.
module draw_ctrl #(
  parameter logic [15:0] WDT_CYCLES = 16'd40000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       go,
  input  logic       frame_tick,
  input  logic       quit,
  input  logic       game_over,
  input  logic       win,
  input  logic       bg_done,
  input  logic       pacman_done,
  input  logic       win_done,
  input  logic       over_done,
  input  logic       exit_done,
  output logic       bg_start,
  output logic       pacman_start,
  output logic       win_start,
  output logic       over_start,
  output logic       exit_start,
  output logic [2:0] MuxSelect,
  output logic       plot_en,
  output logic       busy,
  output logic       frame_overrun,
  output logic       wdt_error
);

  typedef enum logic [2:0] {
    IDLE, DRAW_BG, WAIT_TICK, DRAW_PAC, DRAW_WIN, DRAW_OVER, DRAW_EXIT, HALT
  } state_t;

  function automatic logic is_draw(input state_t s);
    return (s == DRAW_BG) || (s == DRAW_PAC) || (s == DRAW_WIN) ||
           (s == DRAW_OVER) || (s == DRAW_EXIT);
  endfunction

  state_t     state_q, state_d;
  state_t     enter_st, finish_st;
  logic [2:0] mux_q, mux_d;
  logic [4:0] start_q, start_d;   // {bg, pacman, win, over, exit}
  logic       active_q, active_d;
  logic       overrun_q, overrun_d;
  logic       enter;
  logic       done_sel;
  logic       done_ok;

`ifdef DRAW_WATCHDOG_EN
  logic [15:0] wdt_cnt_q, wdt_cnt_d;
  logic        wdt_err_q, wdt_err_d;
`else
  logic [15:0] wdt_cfg_unused;
  assign wdt_cfg_unused = WDT_CYCLES;
`endif

  always_comb begin
    state_d   = state_q;
    mux_d     = mux_q;
    start_d   = '0;
    overrun_d = overrun_q;
    enter     = 1'b0;
    enter_st  = DRAW_BG;
`ifdef DRAW_WATCHDOG_EN
    wdt_cnt_d = wdt_cnt_q;
    wdt_err_d = wdt_err_q;
`endif

    case (state_q)
      DRAW_BG:   done_sel = bg_done;
      DRAW_PAC:  done_sel = pacman_done;
      DRAW_WIN:  done_sel = win_done;
      DRAW_OVER: done_sel = over_done;
      DRAW_EXIT: done_sel = exit_done;
      default:   done_sel = 1'b0;
    endcase
    // A done arriving alongside our own start pulse belongs to a previous draw.
    done_ok   = done_sel && (start_q == 5'b00000);
    finish_st = ((state_q == DRAW_BG) || (state_q == DRAW_PAC)) ? WAIT_TICK : HALT;

    case (state_q)
      IDLE, HALT: begin
        if (go) begin
          enter     = 1'b1;
          enter_st  = DRAW_BG;
          overrun_d = 1'b0;
`ifdef DRAW_WATCHDOG_EN
          wdt_err_d = 1'b0;
`endif
        end
      end
      WAIT_TICK: begin
        if (frame_tick) begin
          enter = 1'b1;
          if (quit)           enter_st = DRAW_EXIT;
          else if (game_over) enter_st = DRAW_OVER;
          else if (win)       enter_st = DRAW_WIN;
          else                enter_st = DRAW_PAC;
        end
      end
      default: begin
        if (frame_tick && ((state_q == DRAW_BG) || (state_q == DRAW_PAC)))
          overrun_d = 1'b1;
        if (done_ok) begin
          state_d = finish_st;
        end
`ifdef DRAW_WATCHDOG_EN
        else if (wdt_cnt_q + 16'd1 == WDT_CYCLES) begin
          state_d   = finish_st;
          wdt_err_d = 1'b1;
        end else begin
          wdt_cnt_d = wdt_cnt_q + 16'd1;
        end
`endif
      end
    endcase

    if (enter) begin
      state_d = enter_st;
`ifdef DRAW_WATCHDOG_EN
      wdt_cnt_d = '0;
`endif
      case (enter_st)
        DRAW_BG:   begin mux_d = 3'b000; start_d = 5'b10000; end
        DRAW_PAC:  begin mux_d = 3'b001; start_d = 5'b01000; end
        DRAW_WIN:  begin mux_d = 3'b010; start_d = 5'b00100; end
        DRAW_OVER: begin mux_d = 3'b011; start_d = 5'b00010; end
        DRAW_EXIT: begin mux_d = 3'b100; start_d = 5'b00001; end
        default:   begin mux_d = mux_q; start_d = '0; end
      endcase
    end

    // plot_en and busy coincide: a watchdog abort leaves the DRAW state too.
    active_d = is_draw(state_d);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      mux_q     <= 3'b000;
      start_q   <= '0;
      active_q  <= 1'b0;
      overrun_q <= 1'b0;
`ifdef DRAW_WATCHDOG_EN
      wdt_cnt_q <= '0;
      wdt_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      mux_q     <= mux_d;
      start_q   <= start_d;
      active_q  <= active_d;
      overrun_q <= overrun_d;
`ifdef DRAW_WATCHDOG_EN
      wdt_cnt_q <= wdt_cnt_d;
      wdt_err_q <= wdt_err_d;
`endif
    end
  end

  assign bg_start      = start_q[4];
  assign pacman_start  = start_q[3];
  assign win_start     = start_q[2];
  assign over_start    = start_q[1];
  assign exit_start    = start_q[0];
  assign MuxSelect     = mux_q;
  assign plot_en       = active_q;
  assign busy          = active_q;
  assign frame_overrun = overrun_q;
`ifdef DRAW_WATCHDOG_EN
  assign wdt_error     = wdt_err_q;
`else
  assign wdt_error     = 1'b0;
`endif

endmodule

// File: tb/tb_draw_ctrl.sv
// Directed bench for draw_ctrl: sequencing, done/tick corner cases, watchdog and async reset.
module tb_draw_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic go = 0, frame_tick = 0, quit = 0, game_over = 0, win = 0;
  logic bg_done = 0, pacman_done = 0, win_done = 0, over_done = 0, exit_done = 0;
  logic bg_start, pacman_start, win_start, over_start, exit_start;
  logic [2:0] MuxSelect;
  logic plot_en, busy, frame_overrun, wdt_error;
  logic [4:0] st;

  int n_checks = 0;
  int n_fail   = 0;

  draw_ctrl #(.WDT_CYCLES(16'd16)) dut (
    .clock(clock), .reset(reset), .go(go), .frame_tick(frame_tick),
    .quit(quit), .game_over(game_over), .win(win),
    .bg_done(bg_done), .pacman_done(pacman_done), .win_done(win_done),
    .over_done(over_done), .exit_done(exit_done),
    .bg_start(bg_start), .pacman_start(pacman_start), .win_start(win_start),
    .over_start(over_start), .exit_start(exit_start),
    .MuxSelect(MuxSelect), .plot_en(plot_en), .busy(busy),
    .frame_overrun(frame_overrun), .wdt_error(wdt_error)
  );

  assign st = {bg_start, pacman_start, win_start, over_start, exit_start};

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    // reset state, checked while reset is held
    #2;
    chk("rst_mux", 8'(MuxSelect), 8'h0);
    chk("rst_start", 8'(st), 8'h00);
    chk("rst_plot", 8'(plot_en), 8'h0);
    chk("rst_busy", 8'(busy), 8'h0);
    chk("rst_ovr", 8'(frame_overrun), 8'h0);
    chk("rst_wdt", 8'(wdt_error), 8'h0);
    #10 reset = 1'b0;
    step(2);
    chk("idle_busy", 8'(busy), 8'h0);

    // go -> DRAW_BG
    go = 1; step(); go = 0;
    chk("bg_start", 8'(st), 8'h10);
    chk("bg_mux", 8'(MuxSelect), 8'h0);
    chk("bg_plot", 8'(plot_en), 8'h1);
    chk("bg_busy", 8'(busy), 8'h1);
    step();
    chk("bg_pulse_1cyc", 8'(st), 8'h00);
    chk("bg_plot_hold", 8'(plot_en), 8'h1);
    step(8);
    bg_done = 1; step(); bg_done = 0;
    chk("bg_done_plot", 8'(plot_en), 8'h0);
    chk("bg_done_busy", 8'(busy), 8'h0);
    chk("wait_mux_hold", 8'(MuxSelect), 8'h0);

    // go ignored in WAIT_TICK
    go = 1; step(); go = 0;
    chk("wait_go_ign", 8'(st), 8'h00);
    chk("wait_go_busy", 8'(busy), 8'h0);

    // normal tick -> DRAW_PAC; done on start cycle ignored
    frame_tick = 1; step(); frame_tick = 0;
    chk("pac_start", 8'(st), 8'h08);
    chk("pac_mux", 8'(MuxSelect), 8'h1);
    pacman_done = 1; step(); pacman_done = 0;
    chk("pac_early_done_busy", 8'(busy), 8'h1);
    chk("pac_early_done_plot", 8'(plot_en), 8'h1);
    chk("pac_no_restart", 8'(st), 8'h00);
    bg_done = 1; step(); bg_done = 0;
    chk("pac_wrong_done", 8'(busy), 8'h1);
    go = 1; step(); go = 0;
    chk("pac_go_ign_st", 8'(st), 8'h00);
    chk("pac_go_ign_busy", 8'(busy), 8'h1);

    // tick and done together in DRAW_PAC
    frame_tick = 1; pacman_done = 1; step(); frame_tick = 0; pacman_done = 0;
    chk("pac_tickdone_busy", 8'(busy), 8'h0);
    chk("pac_tickdone_ovr", 8'(frame_overrun), 8'h1);
    chk("pac_tickdone_st", 8'(st), 8'h00);
    step();
    chk("pac_no_second", 8'(st), 8'h00);
    chk("ovr_sticky", 8'(frame_overrun), 8'h1);

    // win path -> HALT, tick ignored in HALT, go restarts and clears overrun
    frame_tick = 1; win = 1; step(); frame_tick = 0; win = 0;
    chk("win_start", 8'(st), 8'h04);
    chk("win_mux", 8'(MuxSelect), 8'h2);
    step();
    win_done = 1; step(); win_done = 0;
    chk("halt_busy", 8'(busy), 8'h0);
    chk("halt_mux_hold", 8'(MuxSelect), 8'h2);
    frame_tick = 1; step(); frame_tick = 0;
    chk("halt_tick_ign", 8'(st), 8'h00);
    go = 1; step(); go = 0;
    chk("restart_bg", 8'(st), 8'h10);
    chk("restart_mux", 8'(MuxSelect), 8'h0);
    chk("restart_ovr_clr", 8'(frame_overrun), 8'h0);
    step();
    bg_done = 1; step(); bg_done = 0;

    // quit has priority over game_over
    frame_tick = 1; quit = 1; game_over = 1; step(); frame_tick = 0; quit = 0; game_over = 0;
    chk("exit_start", 8'(st), 8'h01);
    chk("exit_mux", 8'(MuxSelect), 8'h4);
    step();
    exit_done = 1; step(); exit_done = 0;
    chk("exit_halt_busy", 8'(busy), 8'h0);
    go = 1; step(); go = 0;
    chk("exit_restart_bg", 8'(st), 8'h10);
    chk("exit_restart_mux", 8'(MuxSelect), 8'h0);
    // tick during DRAW_BG
    frame_tick = 1; step(); frame_tick = 0;
    chk("bg_tick_ovr", 8'(frame_overrun), 8'h1);
    chk("bg_tick_busy", 8'(busy), 8'h1);
    bg_done = 1; step(); bg_done = 0;
    chk("bg_done2_busy", 8'(busy), 8'h0);

    // game_over beats win
    frame_tick = 1; game_over = 1; win = 1; step(); frame_tick = 0; game_over = 0; win = 0;
    chk("over_start", 8'(st), 8'h02);
    chk("over_mux", 8'(MuxSelect), 8'h3);
    step();
    over_done = 1; step(); over_done = 0;
    chk("over_halt_busy", 8'(busy), 8'h0);
    go = 1; step(); go = 0;
    step();
    bg_done = 1; step(); bg_done = 0;

    // watchdog: no done after pacman_start
    frame_tick = 1; step(); frame_tick = 0;
    chk("wdt_pac_start", 8'(st), 8'h08);
    step(3);
    frame_tick = 1; step(); frame_tick = 0;
    chk("wdt_pac_tick_ovr", 8'(frame_overrun), 8'h1);
    chk("wdt_pac_tick_st", 8'(st), 8'h00);
    step(11);
    chk("wdt_15_busy", 8'(busy), 8'h1);
    chk("wdt_15_err", 8'(wdt_error), 8'h0);
    step();
`ifdef DRAW_WATCHDOG_EN
    chk("wdt_16_busy", 8'(busy), 8'h0);
    chk("wdt_16_plot", 8'(plot_en), 8'h0);
    chk("wdt_16_err", 8'(wdt_error), 8'h1);
`else
    chk("nowdt_16_busy", 8'(busy), 8'h1);
    chk("nowdt_16_err", 8'(wdt_error), 8'h0);
`endif
    pacman_done = 1; step(); pacman_done = 0;
    chk("wdt_after_busy", 8'(busy), 8'h0);

    // async reset mid DRAW_WIN on its start cycle
    frame_tick = 1; win = 1; step(); frame_tick = 0; win = 0;
    chk("rw_win_start", 8'(st), 8'h04);
    #2 reset = 1'b1;
    #1;
    chk("arst_start", 8'(st), 8'h00);
    chk("arst_mux", 8'(MuxSelect), 8'h0);
    chk("arst_plot", 8'(plot_en), 8'h0);
    chk("arst_busy", 8'(busy), 8'h0);
    chk("arst_ovr", 8'(frame_overrun), 8'h0);
    chk("arst_wdt", 8'(wdt_error), 8'h0);
    #2 reset = 1'b0;
    win_done = 1; step(); win_done = 0;
    chk("post_rst_idle", 8'(busy), 8'h0);
    go = 1; step(); go = 0;
    chk("post_rst_go", 8'(st), 8'h10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
